uart_port_arbiter: RTL and testbench



---
 rtl/uart_port_arbiter_if.sv | 39 +++
 rtl/uart_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_port_arbiter_if.sv
// uart_port_arbiter_if: bundles every non-clock/reset signal of uart_port_arbiter.
//   Requester side : req0/req1 valid/data in, ready pulse out.
//   Rx sink side   : rx_valid/rx_data out, rx_ready in.
//   Status         : tx_stall out (sticky).
//   UART bus side  : active-low cs/rd/wr, 3-bit addr, wdata out; combinational rdata in.
// master: the arbiter's view. slave: the view of everything around it.
interface uart_port_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  logic       tx_stall;

  logic       uart_cs;
  logic       uart_rd;
  logic       uart_wr;
  logic [2:0] uart_addr;
  logic [7:0] uart_wdata;
  logic [7:0] uart_rdata;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, rx_ready, uart_rdata,
    output req0_ready, req1_ready, rx_valid, rx_data, tx_stall,
    output uart_cs, uart_rd, uart_wr, uart_addr, uart_wdata
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, rx_ready, uart_rdata,
    input  req0_ready, req1_ready, rx_valid, rx_data, tx_stall,
    input  uart_cs, uart_rd, uart_wr, uart_addr, uart_wdata
  );
endinterface

// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter: shares one memory-mapped UART between two byte transmit requesters and
// drains its Rx buffer into one sink.
//   clk_i   : system clock.
//   rst_ni  : synchronous active-low reset.
//   bus_io  : uart_port_arbiter_if.master (requesters, Rx sink, tx_stall, UART cs/rd/wr bus).
// Idle cycles peek the control register (addr 0); Rx reads (addr 1) take priority over
// round-robin Tx writes (addr 2). Every access is followed by GUARD_CYCLES idle bus cycles.
// Optional feature macro: UART_ARB_RX_EN compiles in the Rx read path and Rx sink registers.
// Without it RX_AVAL is ignored and rx_valid/rx_data are tied to 0.
module uart_port_arbiter #(
  parameter int unsigned TX_BUSY_BIT  = 1,
  parameter int unsigned RX_AVAL_BIT  = 2,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 4096
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  uart_port_arbiter_if.master bus_io
);

  localparam int unsigned     CntW       = $clog2(TIMEOUT + 1);
  localparam logic [2:0]      TxBusyIdx  = 3'(TX_BUSY_BIT);
  localparam logic [3:0]      GuardLoad  = 4'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StTxWrite, StRxRead, StGuard} state_e;

  state_e          state_q;
  logic [3:0]      guard_q;
  logic [CntW-1:0] tmo_q;
  logic            last_grant_q;
  logic            tx_stall_q;
  logic            cs_q, rd_q, wr_q;
  logic [2:0]      addr_q;
  logic [7:0]      wdata_q;
  logic            req0_ready_q, req1_ready_q;

  logic peek, tx_busy, any_req, tx_go, rx_go, grant;

  // The first IDLE cycle after reset still has cs high, so it is not a valid peek.
  assign peek    = (state_q == StIdle) && !cs_q;
  assign tx_busy = bus_io.uart_rdata[TxBusyIdx];
  assign any_req = bus_io.req0_valid | bus_io.req1_valid;
  assign tx_go   = !tx_busy && any_req;
  // A lone requester always wins; a tie goes to whoever did not win last time.
  assign grant   = (bus_io.req0_valid && bus_io.req1_valid) ? ~last_grant_q : bus_io.req1_valid;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      guard_q      <= '0;
      tmo_q        <= '0;
      last_grant_q <= 1'b1;
      tx_stall_q   <= 1'b0;
      cs_q         <= 1'b1;
      rd_q         <= 1'b1;
      wr_q         <= 1'b1;
      addr_q       <= 3'd0;
      wdata_q      <= 8'h00;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
    end else begin
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!peek) begin
            cs_q <= 1'b0;
          end else if (rx_go) begin
            state_q <= StRxRead;
            rd_q    <= 1'b0;
            addr_q  <= 3'd1;
          end else if (tx_go) begin
            state_q      <= StTxWrite;
            wr_q         <= 1'b0;
            addr_q       <= 3'd2;
            wdata_q      <= grant ? bus_io.req1_data : bus_io.req0_data;
            req0_ready_q <= ~grant;
            req1_ready_q <= grant;
            last_grant_q <= grant;
          end else if (tx_busy && any_req && tmo_q != TimeoutVal) begin
            // Saturates at TIMEOUT; stall flag rises on the same edge the count gets there.
            tmo_q <= tmo_q + 1'b1;
            if (tmo_q == TimeoutVal - 1'b1) begin
              tx_stall_q <= 1'b1;
            end
          end
        end
        StTxWrite: begin
          state_q <= StGuard;
          guard_q <= GuardLoad;
          tmo_q   <= '0;
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= 3'd0;
          wdata_q <= 8'h00;
        end
        StRxRead: begin
          state_q <= StGuard;
          guard_q <= GuardLoad;
          cs_q    <= 1'b1;
          rd_q    <= 1'b1;
          addr_q  <= 3'd0;
        end
        StGuard: begin
          if (guard_q == 4'd0) begin
            state_q <= StIdle;
            cs_q    <= 1'b0;
          end else begin
            guard_q <= guard_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef UART_ARB_RX_EN
  localparam logic [2:0] RxAvalIdx = 3'(RX_AVAL_BIT);

  logic       rx_valid_q;
  logic [7:0] rx_data_q;

  // A held byte blocks further reads, so the UART keeps anything newer.
  assign rx_go = bus_io.uart_rdata[RxAvalIdx] && !rx_valid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else if (state_q == StRxRead) begin
      rx_valid_q <= 1'b1;
      rx_data_q  <= bus_io.uart_rdata;
    end else if (rx_valid_q && bus_io.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign bus_io.rx_valid = rx_valid_q;
  assign bus_io.rx_data  = rx_data_q;
`else
  logic unused_rx;

  assign rx_go           = 1'b0;
  assign bus_io.rx_valid = 1'b0;
  assign bus_io.rx_data  = 8'h00;
  assign unused_rx       = ^{bus_io.rx_ready, bus_io.uart_rdata, 3'(RX_AVAL_BIT)};
`endif

  assign bus_io.uart_cs    = cs_q;
  assign bus_io.uart_rd    = rd_q;
  assign bus_io.uart_wr    = wr_q;
  assign bus_io.uart_addr  = addr_q;
  assign bus_io.uart_wdata = wdata_q;
  assign bus_io.req0_ready = req0_ready_q;
  assign bus_io.req1_ready = req1_ready_q;
  assign bus_io.tx_stall   = tx_stall_q;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter (TIMEOUT=16, other parameters at defaults).
// A small UART model answers peeks/reads; requester queues drop each byte on its ready pulse.
// Written bytes and received bytes are checked against expectation queues.
module tb_uart_port_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_port_arbiter_if bus ();

  uart_port_arbiter #(
    .TIMEOUT(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  logic [7:0] ctrl    = 8'h00;
  logic [7:0] rx_byte = 8'h00;

  assign bus.uart_rdata = (bus.uart_addr == 3'd0) ? ctrl :
                          (bus.uart_addr == 3'd1) ? rx_byte : 8'h00;

  int         n_cmp  = 0;
  int         n_bad  = 0;
  int         cyc    = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic       rx_prev = 1'b0;
  logic [9:0] wr_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx0[$];
  logic [7:0] tx1[$];

  localparam logic [25:0] ResetVals = {3'b111, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check(tag, 32'({bus.uart_cs, bus.uart_rd, bus.uart_wr, bus.uart_addr, bus.uart_wdata,
                    bus.req0_ready, bus.req1_ready, bus.rx_valid, bus.rx_data, bus.tx_stall}),
          32'(ResetVals));
  endtask

  task automatic refresh_req();
    bus.req0_valid = (tx0.size() != 0);
    bus.req0_data  = (tx0.size() != 0) ? tx0[0] : 8'h00;
    bus.req1_valid = (tx1.size() != 0);
    bus.req1_data  = (tx1.size() != 0) ? tx1[0] : 8'h00;
  endtask

  task automatic enq(input int r, input logic [7:0] d);
    if (r == 0) tx0.push_back(d);
    else        tx1.push_back(d);
    refresh_req();
  endtask

  task automatic expect_wr(input int r, input logic [7:0] d);
    wr_exp.push_back({(r == 1), (r == 0), d});
  endtask

  // One clock; samples 1 time unit after the edge, then plays UART and requesters.
  task automatic tick();
    logic [9:0] we;
    logic [7:0] re;
    @(posedge clk);
    #1;
    cyc++;
    if (!bus.uart_cs && !bus.uart_wr) begin
      wr_cnt++;
      check("wr_addr", 32'(bus.uart_addr), 32'd2);
      check("wr_expected", 32'(wr_exp.size() != 0), 32'd1);
      if (wr_exp.size() != 0) begin
        we = wr_exp.pop_front();
        check("wr_byte", 32'({bus.req1_ready, bus.req0_ready, bus.uart_wdata}), 32'(we));
      end
    end
    if (!bus.uart_cs && !bus.uart_rd && bus.uart_addr == 3'd1) begin
      rd_cnt++;
      ctrl[2] = 1'b0;
    end
    if (bus.rx_valid && !rx_prev) begin
      check("rx_expected", 32'(rx_exp.size() != 0), 32'd1);
      if (rx_exp.size() != 0) begin
        re = rx_exp.pop_front();
        check("rx_byte", 32'(bus.rx_data), 32'(re));
      end
    end
    rx_prev = bus.rx_valid;
    if (bus.req0_ready && tx0.size() != 0) tx0.delete(0);
    if (bus.req1_ready && tx1.size() != 0) tx1.delete(0);
    refresh_req();
  endtask

  task automatic wait_wr(input string tag, input int limit);
    int start;
    start = wr_cnt;
    for (int i = 0; i < limit && wr_cnt == start; i++) tick();
    check(tag, 32'(wr_cnt - start), 32'd1);
  endtask

  initial begin
    int t_prev;
    int wr0;
    int rd0;
    t_prev = 0;
    bus.rx_ready = 1'b0;
    refresh_req();

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset("reset_values");
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_peek", 32'({bus.uart_cs, bus.uart_rd, bus.uart_wr, bus.uart_addr}),
          32'({1'b0, 1'b1, 1'b1, 3'd0}));

    // Single requester
    enq(0, 8'h41);
    expect_wr(0, 8'h41);
    tick();
    check("t1_write", 32'({bus.uart_cs, bus.uart_wr, bus.uart_addr, bus.uart_wdata,
                           bus.req0_ready, bus.req1_ready}),
          32'({1'b0, 1'b0, 3'd2, 8'h41, 1'b1, 1'b0}));
    tick();
    check("t1_guard1", 32'({bus.uart_cs, bus.uart_rd, bus.uart_wr, bus.req0_ready}),
          32'({1'b1, 1'b1, 1'b1, 1'b0}));
    tick();
    check("t1_guard2", 32'(bus.uart_cs), 32'd1);
    tick();
    check("t1_peek", 32'({bus.uart_cs, bus.uart_rd, bus.uart_wr, bus.uart_addr}),
          32'({1'b0, 1'b1, 1'b1, 3'd0}));
    repeat (6) tick();
    check("t1_one_write", 32'(wr_cnt), 32'd1);

    // Tie round-robin from a fresh reset: requester 0 wins the first tie
    rst_n = 1'b0;
    tick();
    check_reset("reset_again");
    rst_n = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      enq(0, 8'h10 + 8'(i));
      enq(1, 8'h20 + 8'(i));
      expect_wr(0, 8'h10 + 8'(i));
      expect_wr(1, 8'h20 + 8'(i));
    end
    for (int k = 0; k < 8; k++) begin
      wait_wr("tie_wr", 8);
      if (k > 0) check("tie_cadence", 32'(cyc - t_prev), 32'd4);
      t_prev = cyc;
    end
    repeat (6) tick();
    check("tie_all_written", 32'({wr_exp.size(), wr_cnt}), 32'({0, 9}));

    // Busy hold-off with timeout
    check("busy_pre_peek", 32'(bus.uart_cs), 32'd0);
    ctrl = 8'h02;
    enq(1, 8'h77);
    expect_wr(1, 8'h77);
    wr0 = wr_cnt;
    repeat (15) tick();
    check("stall_before", 32'(bus.tx_stall), 32'd0);
    tick();
    check("stall_set", 32'(bus.tx_stall), 32'd1);
    repeat (84) tick();
    check("busy_no_wr", 32'(wr_cnt - wr0), 32'd0);
    ctrl = 8'h00;
    tick();
    check("busy_release_wr", 32'({bus.uart_wr, bus.req1_ready}), 32'({1'b0, 1'b1}));
    check("stall_sticky", 32'(bus.tx_stall), 32'd1);
    repeat (6) tick();

`ifdef UART_ARB_RX_EN
    // Rx read, hold, clear
    rx_byte = 8'h5A;
    ctrl    = 8'h04;
    rx_exp.push_back(8'h5A);
    rd0 = rd_cnt;
    tick();
    check("rx_read", 32'({bus.uart_cs, bus.uart_rd, bus.uart_wr, bus.uart_addr}),
          32'({1'b0, 1'b0, 1'b1, 3'd1}));
    tick();
    check("rx_latency", 32'({bus.rx_valid, bus.rx_data}), 32'({1'b1, 8'h5A}));
    ctrl    = 8'h04;
    rx_byte = 8'hA5;
    repeat (10) tick();
    check("rx_hold", 32'({bus.rx_valid, bus.rx_data}), 32'({1'b1, 8'h5A}));
    check("rx_no_overwrite", 32'(rd_cnt - rd0), 32'd1);
    rx_exp.push_back(8'hA5);
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    check("rx_clear", 32'(bus.rx_valid), 32'd0);
    for (int i = 0; i < 10 && !bus.rx_valid; i++) tick();
    check("rx_second", 32'({bus.rx_valid, bus.rx_data}), 32'({1'b1, 8'hA5}));
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    repeat (6) tick();

    // Rx has priority over a simultaneous Tx request
    ctrl    = 8'h04;
    rx_byte = 8'h3C;
    rx_exp.push_back(8'h3C);
    enq(0, 8'h55);
    expect_wr(0, 8'h55);
    tick();
    check("prio_rx_first", 32'({bus.uart_rd, bus.uart_wr, bus.uart_addr}),
          32'({1'b0, 1'b1, 3'd1}));
    wait_wr("prio_tx_after", 8);
    check("prio_rx_held", 32'({bus.rx_valid, bus.rx_data}), 32'({1'b1, 8'h3C}));
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
`else
    // RX_AVAL is ignored: the Tx request goes straight to the bus
    ctrl = 8'h04;
    enq(0, 8'h66);
    expect_wr(0, 8'h66);
    rd0 = rd_cnt;
    tick();
    check("norx_tx_direct", 32'({bus.uart_rd, bus.uart_wr, bus.uart_addr}),
          32'({1'b1, 1'b0, 3'd2}));
    repeat (6) tick();
    check("norx_no_read", 32'(rd_cnt - rd0), 32'd0);
    check("norx_rx_tied", 32'({bus.rx_valid, bus.rx_data}), 32'd0);
    ctrl = 8'h00;
`endif
    repeat (4) tick();

    // Reset during TX_WRITE
    enq(0, 8'h99);
    expect_wr(0, 8'h99);
    tick();
    check("rst_mid_write", 32'({bus.uart_wr, bus.req0_ready, bus.tx_stall}),
          32'({1'b0, 1'b1, 1'b1}));
    rst_n = 1'b0;
    tick();
    check_reset("rst_mid_values");
    rst_n = 1'b1;
    repeat (4) tick();
    check("sb_drained", 32'(wr_exp.size()), 32'd0);
    check("total_writes", 32'(wr_cnt), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
